// File: rtl/antiglitch_axil_slave.sv
`default_nettype none
// ============================================================================
// antiglitch_axil_slave : AXI4-Lite register block with a programmable glitch
//                         filter (sig_in -> sig_out) and a glitch counter.
// Revision: 1.0 - initial release
// ============================================================================
module antiglitch_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_SYNC_STAGES      = 2
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sig_in,
  output logic                            sig_out
);

  localparam int c_strb_w = C_S_AXI_DATA_WIDTH / 8;

  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
  logic [31:0]                   r_glitch_cnt;
  logic [C_SYNC_STAGES-1:0]      r_sync;
  logic [15:0]                   r_flt_cnt;
  logic                          r_sig_out;

  logic                          w_wr_accept;
  logic                          w_rd_accept;
  logic [2:0]                    w_wr_sel;
  logic [2:0]                    w_rd_sel;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
  logic                          w_s;
  logic                          w_flt_en;
  logic [15:0]                   w_stable_len;
  logic                          w_unused;

  assign w_wr_accept  = S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid && !r_awready;
  assign w_rd_accept  = S_AXI_ARVALID && !r_rvalid && !r_arready;
  assign w_wr_sel     = S_AXI_AWADDR[4:2];
  assign w_rd_sel     = S_AXI_ARADDR[4:2];
  assign w_s          = r_sync[C_SYNC_STAGES-1];
  assign w_flt_en     = r_regs[0][0];
  assign w_stable_len = r_regs[1][15:0];
  assign w_unused     = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = r_rvalid;
  assign sig_out       = r_sig_out;

  // Write channel: AW and W are only taken together, one beat at a time.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_awready <= w_wr_accept;
      if (r_awready) begin
        r_bvalid <= 1'b1;
        if (!w_wr_sel[2]) begin
          for (int b = 0; b < c_strb_w; b++) begin
            if (S_AXI_WSTRB[b]) r_regs[w_wr_sel[1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
          end
        end
      end else if (r_bvalid && S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (w_rd_sel)
      3'd0:    w_rd_data = r_regs[0];
      3'd1:    w_rd_data = r_regs[1];
      3'd2:    w_rd_data = r_regs[2];
      3'd3:    w_rd_data = r_regs[3];
      3'd4:    w_rd_data = r_glitch_cnt;
      default: w_rd_data = '0;
    endcase
  end

  // Read data is sampled alongside the write update, so a same-cycle read sees the old value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= w_rd_accept;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_sync <= '0;
    else        r_sync <= {r_sync[C_SYNC_STAGES-2:0], sig_in};
  end

  // Counter saturates so a STABLE_LEN lowered below it can never be matched by wrap-around.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_sig_out    <= 1'b0;
      r_flt_cnt    <= '0;
      r_glitch_cnt <= '0;
    end else if (!w_flt_en) begin
      r_sig_out <= w_s;
      r_flt_cnt <= '0;
    end else if (w_s == r_sig_out) begin
      if (r_flt_cnt != 16'd0 && r_glitch_cnt != 32'hFFFF_FFFF)
        r_glitch_cnt <= r_glitch_cnt + 32'd1;
      r_flt_cnt <= '0;
    end else if (r_flt_cnt == w_stable_len) begin
      r_sig_out <= w_s;
      r_flt_cnt <= '0;
    end else if (r_flt_cnt != 16'hFFFF) begin
      r_flt_cnt <= r_flt_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_antiglitch_axil_slave.sv
`default_nettype none
// ============================================================================
// tb_antiglitch_axil_slave : directed self-checking bench for antiglitch_axil_slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_antiglitch_axil_slave;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESET;
  logic [4:0]  tb_AWADDR;
  logic [2:0]  tb_AWPROT;
  logic        tb_AWVALID;
  logic        tb_AWREADY;
  logic [31:0] tb_WDATA;
  logic [3:0]  tb_WSTRB;
  logic        tb_WVALID;
  logic        tb_WREADY;
  logic [1:0]  tb_BRESP;
  logic        tb_BVALID;
  logic        tb_BREADY;
  logic [4:0]  tb_ARADDR;
  logic [2:0]  tb_ARPROT;
  logic        tb_ARVALID;
  logic        tb_ARREADY;
  logic [31:0] tb_RDATA;
  logic [1:0]  tb_RRESP;
  logic        tb_RVALID;
  logic        tb_RREADY;
  logic        tb_sig_in;
  logic        tb_sig_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 tb_ACLK = ~tb_ACLK;

  antiglitch_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .C_SYNC_STAGES(2)
  ) u_dut (
    .ACLK(tb_ACLK), .ARESET(tb_ARESET),
    .S_AXI_AWADDR(tb_AWADDR), .S_AXI_AWPROT(tb_AWPROT), .S_AXI_AWVALID(tb_AWVALID),
    .S_AXI_AWREADY(tb_AWREADY), .S_AXI_WDATA(tb_WDATA), .S_AXI_WSTRB(tb_WSTRB),
    .S_AXI_WVALID(tb_WVALID), .S_AXI_WREADY(tb_WREADY), .S_AXI_BRESP(tb_BRESP),
    .S_AXI_BVALID(tb_BVALID), .S_AXI_BREADY(tb_BREADY), .S_AXI_ARADDR(tb_ARADDR),
    .S_AXI_ARPROT(tb_ARPROT), .S_AXI_ARVALID(tb_ARVALID), .S_AXI_ARREADY(tb_ARREADY),
    .S_AXI_RDATA(tb_RDATA), .S_AXI_RRESP(tb_RRESP), .S_AXI_RVALID(tb_RVALID),
    .S_AXI_RREADY(tb_RREADY), .sig_in(tb_sig_in), .sig_out(tb_sig_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    tb_AWADDR = addr; tb_WDATA = data; tb_WSTRB = strb;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!tb_AWREADY && n < 20);
    check("wr_awready", {31'd0, tb_AWREADY}, 32'd1);
    check("wr_wready", {31'd0, tb_WREADY}, 32'd1);
    tick();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0;
    check("wr_bvalid", {31'd0, tb_BVALID}, 32'd1);
    check("wr_bresp", {30'd0, tb_BRESP}, 32'd0);
    tb_BREADY = 1'b1;
    tick();
    tb_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output int lat);
    tb_ARADDR = addr; tb_ARVALID = 1'b1;
    lat = 0;
    do begin
      tick(); lat++;
      if (tb_ARREADY) tb_ARVALID = 1'b0;
    end while (!tb_RVALID && lat < 20);
    tb_ARVALID = 1'b0;
    check("rd_rvalid", {31'd0, tb_RVALID}, 32'd1);
    check("rd_rresp", {30'd0, tb_RRESP}, 32'd0);
    data = tb_RDATA;
    tb_RREADY = 1'b1;
    tick();
    tb_RREADY = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int          lat;
    axi_read(addr, d, lat);
    check(tag, d, exp);
  endtask

  task automatic do_reset();
    tb_ARESET = 1'b1;
    repeat (2) tick();
    tb_ARESET = 1'b0;
  endtask

  logic [31:0] c_init_data [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};

  initial begin
    logic [31:0] d;
    int          lat;
    int          n;
    logic        saw_high;

    tb_ARESET = 1'b1; tb_AWADDR = '0; tb_AWPROT = '0; tb_AWVALID = 1'b0;
    tb_WDATA = '0; tb_WSTRB = '0; tb_WVALID = 1'b0; tb_BREADY = 1'b0;
    tb_ARADDR = '0; tb_ARPROT = '0; tb_ARVALID = 1'b0; tb_RREADY = 1'b0;
    tb_sig_in = 1'b0;
    repeat (3) tick();
    check("rst_awready", {31'd0, tb_AWREADY}, 32'd0);
    check("rst_bvalid", {31'd0, tb_BVALID}, 32'd0);
    check("rst_arready", {31'd0, tb_ARREADY}, 32'd0);
    check("rst_rvalid", {31'd0, tb_RVALID}, 32'd0);
    check("rst_rdata", tb_RDATA, 32'd0);
    check("rst_sig_out", {31'd0, tb_sig_out}, 32'd0);
    tb_ARESET = 1'b0;
    tick();

    // Full-word write / readback of the four registers
    for (int i = 0; i < 4; i++) axi_write(5'(4*i), c_init_data[i], 4'hF);
    for (int i = 0; i < 4; i++) read_check("readback", 5'(4*i), c_init_data[i]);
    axi_read(5'h00, d, lat);
    check("read_latency", lat, 2);

    // Byte strobes and discarded writes
    do_reset();
    axi_write(5'h08, 32'hFFFFFFFF, 4'b0101);
    read_check("strobe_0101", 5'h08, 32'h00FF00FF);
    axi_write(5'h10, 32'hDEADBEEF, 4'hF);
    read_check("glitch_ro", 5'h10, 32'd0);
    axi_write(5'h14, 32'hDEADBEEF, 4'hF);
    read_check("addr_0x14", 5'h14, 32'd0);
    read_check("addr_0x1c", 5'h1C, 32'd0);

    // AW ahead of W, BREADY held off, second write stalled behind BVALID
    tb_AWADDR = 5'h0C; tb_WDATA = 32'h0BADCAFE; tb_WSTRB = 4'hF;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b0;
    repeat (3) begin tick(); check("aw_without_w", {31'd0, tb_AWREADY}, 32'd0); end
    tb_WVALID = 1'b1;
    tick();
    check("aw_w_accept", {31'd0, tb_AWREADY}, 32'd1);
    tick();
    check("bp_bvalid_rise", {31'd0, tb_BVALID}, 32'd1);
    tb_AWADDR = 5'h08; tb_WDATA = 32'h55AA55AA;
    repeat (4) begin
      tick();
      check("bp_bvalid_hold", {31'd0, tb_BVALID}, 32'd1);
      check("bp_no_accept", {31'd0, tb_AWREADY}, 32'd0);
    end
    tb_BREADY = 1'b1;
    tick();
    tb_BREADY = 1'b0;
    check("bp_bvalid_fall", {31'd0, tb_BVALID}, 32'd0);
    tick();
    check("bp_second_accept", {31'd0, tb_AWREADY}, 32'd1);
    tick();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0;
    check("bp_second_bvalid", {31'd0, tb_BVALID}, 32'd1);
    tb_BREADY = 1'b1;
    tick();
    tb_BREADY = 1'b0;
    read_check("bp_reg3", 5'h0C, 32'h0BADCAFE);
    read_check("bp_reg2", 5'h08, 32'h55AA55AA);

    // Filter: 3-cycle pulse is a glitch, held level passes after STABLE_LEN+1
    axi_write(5'h04, 32'd5, 4'hF);
    axi_write(5'h00, 32'd1, 4'hF);
    repeat (4) tick();
    tb_sig_in = 1'b1;
    repeat (3) tick();
    tb_sig_in = 1'b0;
    saw_high = 1'b0;
    repeat (15) begin tick(); if (tb_sig_out) saw_high = 1'b1; end
    check("glitch_sig_out", {31'd0, saw_high}, 32'd0);
    read_check("glitch_cnt_1", 5'h10, 32'd1);
    tb_sig_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!tb_sig_out && n < 40);
    check("filter_rise_delay", n, 8);
    read_check("glitch_cnt_still_1", 5'h10, 32'd1);

    // Same-cycle write and read of REG1
    axi_write(5'h04, 32'habcd0001, 4'hF);
    tb_AWADDR = 5'h04; tb_WDATA = 32'h12345678; tb_WSTRB = 4'hF;
    tb_ARADDR = 5'h04;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1; tb_ARVALID = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!tb_AWREADY && n < 20);
    check("sim_awready", {31'd0, tb_AWREADY}, 32'd1);
    check("sim_arready", {31'd0, tb_ARREADY}, 32'd1);
    tick();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0; tb_ARVALID = 1'b0;
    check("sim_bvalid", {31'd0, tb_BVALID}, 32'd1);
    check("sim_rvalid", {31'd0, tb_RVALID}, 32'd1);
    check("sim_old_value", tb_RDATA, 32'habcd0001);
    tb_BREADY = 1'b1; tb_RREADY = 1'b1;
    tick();
    tb_BREADY = 1'b0; tb_RREADY = 1'b0;
    read_check("sim_new_value", 5'h04, 32'h12345678);

    // Reset while BVALID is outstanding
    tb_sig_in = 1'b0;
    axi_write(5'h04, 32'd5, 4'hF);
    tb_AWADDR = 5'h08; tb_WDATA = 32'hA5A5A5A5; tb_WSTRB = 4'hF;
    tb_AWVALID = 1'b1; tb_WVALID = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!tb_AWREADY && n < 20);
    tick();
    tb_AWVALID = 1'b0; tb_WVALID = 1'b0;
    check("rst_pre_bvalid", {31'd0, tb_BVALID}, 32'd1);
    tb_ARESET = 1'b1;
    tick();
    tb_ARESET = 1'b0;
    check("rst_mid_bvalid", {31'd0, tb_BVALID}, 32'd0);
    check("rst_mid_sig_out", {31'd0, tb_sig_out}, 32'd0);
    repeat (3) begin tick(); check("rst_no_late_bvalid", {31'd0, tb_BVALID}, 32'd0); end
    for (int i = 0; i < 5; i++) read_check("rst_reg_zero", 5'(4*i), 32'd0);
    check("rst_final_sig_out", {31'd0, tb_sig_out}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/antiglitch_axil_slave.md
Name: antiglitch_axil_slave

Overview:
- AXI4-Lite responder for the antiglitch IP; it is the slave end of the S00_AXI interface that the master BFM drives.
- Provides four read/write 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC, plus a read-only glitch counter at 0x10.
- Contains a programmable stability filter that removes glitches from sig_in and drives the clean result on sig_out.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, AXI address width; bits [4:2] select the register.
- C_SYNC_STAGES, 2, number of input synchronizer flops on sig_in; minimum 2.

Ports:
- ACLK  in  1  clock for all logic
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  5  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address accepted
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data accepted
- S_AXI_BRESP  out  2  write response, always 2'b00 (OKAY)
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response taken
- S_AXI_ARADDR  in  5  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address accepted
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response, always 2'b00 (OKAY)
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data taken
- sig_in  in  1  asynchronous raw input
- sig_out  out  1  filtered output

Behaviour:
- Reset (ARESET=1 at a rising ACLK edge):
  - all AXI READY/VALID outputs = 0; RDATA = 0; BRESP/RRESP = 0.
  - REG0..REG3 = 0; GLITCH_CNT = 0; sig_out = 0; synchronizer flops = 0; filter counter = 0.
  - Reset mid-transaction aborts it; no BVALID/RVALID is issued afterwards for the aborted transaction.
- Write channel:
  - Accept when AWVALID && WVALID && !BVALID && !AWREADY. AWREADY and WREADY pulse high together for exactly one cycle.
  - The register update happens on the edge that ends that handshake cycle; BVALID rises on the same edge.
  - BVALID holds until BREADY is sampled high, then falls. A new write is not accepted while BVALID=1.
  - AW arriving without W (or W without AW) waits; no partial acceptance.
  - WSTRB[n] enables byte n. A write to 0x10 or to 0x14–0x1C is discarded and still returns OKAY.
- Read channel:
  - Accept when ARVALID && !RVALID && !ARREADY. ARREADY pulses for one cycle.
  - RDATA is captured on the edge ending that cycle, RVALID rises on the same edge, and RDATA is held stable until the RVALID&&RREADY handshake.
  - Read latency from ARVALID to RVALID is 2 cycles.
  - Decode by addr[4:2]: 0..3 return REG0..REG3; 4 returns GLITCH_CNT; 5..7 return 0.
- Simultaneous read and write handshakes: both proceed. A read of the register being written in that cycle returns the pre-write value.
- Register meaning:
  - REG0[0] = filter enable; REG1[15:0] = STABLE_LEN.
  - REG0[31:1], REG1[31:16], REG2 and REG3 are scratch; every bit of REG0..REG3 is read/write.
- Filter:
  - sig_in passes through C_SYNC_STAGES flops to give s.
  - Enable = 0: sig_out <= s each cycle; the counter is held at 0.
  - Enable = 1:
    - If s == sig_out: counter <= 0.
    - Else if counter == STABLE_LEN: sig_out <= s and counter <= 0.
    - Else: counter <= counter + 1.
    - A candidate level that reverts before being accepted (s returns to sig_out while counter ≠ 0) increments GLITCH_CNT.
  - sig_out therefore changes (STABLE_LEN+1) cycles after s settles. STABLE_LEN = 0 gives a 1-cycle registered follow.
  - Counter is 16 bits. GLITCH_CNT is 32 bits, saturates at 0xFFFFFFFF and does not wrap.
  - Changing STABLE_LEN mid-count takes effect on the next compare. Lowering it below the current count causes no acceptance until the counter returns to 0, i.e. s must revert first.

Test Plan:
- Write 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x0, 0x4, 0x8, 0xC, then read each back -> identical data, BRESP=RRESP=OKAY on every transfer.
- Write 0xFFFFFFFF to 0x8 with WSTRB=4'b0101 after reset -> read of 0x8 returns 0x00FF00FF; write to 0x10 -> OKAY and GLITCH_CNT unchanged.
- AWVALID asserted 3 cycles before WVALID, BREADY held low 4 cycles -> no AWREADY until WVALID; BVALID held 4 cycles; the next write is stalled until then.
- REG0=1, REG1=5; sig_in pulses high for 3 cycles -> sig_out stays 0 and GLITCH_CNT reads 1. sig_in held high -> sig_out rises 6 cycles after the synchronized edge.
- Assert ARESET during an outstanding BVALID with REG1=5 -> BVALID=0 next cycle, and all registers and sig_out read 0.
- Same-cycle write of 0x12345678 to 0x4 and read of 0x4, with REG1 previously 0xabcd0001 -> read returns 0xabcd0001; a following read returns 0x12345678.
